// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-lookahead adder.
//   GROUP_W     : bits per leaf group (lookahead fan-in), fixed at 4.
//   num_groups  : number of 4-bit leaf groups for a given data width.
//   cla_levels  : lookahead tree depth above the leaf row, ceil(log4(num_groups)).
//   pow4        : 4**e, used to size the rows of the padded lookahead tree.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    function automatic int unsigned num_groups(input int unsigned data_w);
        return data_w / GROUP_W;
    endfunction

    function automatic int unsigned cla_levels(input int unsigned data_w);
        int unsigned n;
        int unsigned lv;
        n  = 1;
        lv = 0;
        while (n < num_groups(data_w)) begin
            n  = n * 4;
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic int unsigned pow4(input int unsigned e);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) begin
            r = r * 4;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_lcu4.sv
// 4-input carry-lookahead unit, one node of the lookahead tree (purely combinational).
//   p, g   : propagate/generate of the four children (bit or subgroup level)
//   c_in   : carry into child 0
//   carry  : carries into children 1..3
//   g_out  : group generate  g3 | g2p3 | g1p2p3 | g0p1p2p3
//   p_out  : group propagate (AND of all p)
module cla_lcu4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               c_in,
    output logic [GROUP_W-2:0] carry,
    output logic               g_out,
    output logic               p_out
);

    always_comb begin
        carry[0] = g[0] | (p[0] & c_in);
        carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        carry[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        g_out    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_out    = &p;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready = ~stall)
//   a, b, cin, sub      : operands; sub=1 computes a-b (cin ignored), else a+b+cin
//   out_valid, out_ready: result handshake
//   sum, cout, ovf      : result mod 2^DATA_W, carry out (no-borrow for sub), signed overflow
// Stage 1 registers bitwise propagate and the full bit-carry vector from the lookahead tree;
// stage 2 registers the final sum and flags.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned GROUP_W    = 4,
    parameter bit          SIGNED_OVF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    localparam int unsigned LEVELS = cla_levels(DATA_W);

    if (GROUP_W != cla_pkg::GROUP_W) begin : g_bad_group
        $error("cla_pipe_adder: GROUP_W must be 4");
    end
    if ((DATA_W % 4 != 0) || (DATA_W < 4) || (DATA_W > 256)) begin : g_bad_width
        $error("cla_pipe_adder: DATA_W must be a multiple of 4 in 4..256");
    end

    // ---------------------------------------------------------------- handshake
    logic stall;
    logic out_valid_q;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    // ---------------------------------------------------------------- stage 1 comb
    logic [DATA_W-1:0] b_eff;
    logic              c0;
    logic [DATA_W-1:0] p_bit;
    logic [DATA_W-1:0] g_bit;
    logic [DATA_W:0]   c_bit;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
        p_bit = a ^ b_eff;
        g_bit = a & b_eff;
    end

    // Row r holds 4**(LEVELS-r) lookahead nodes; row 0 works on bits, the single node of
    // row LEVELS is the root. The tree is padded to a full 4-ary shape: bits above DATA_W
    // get p=1, g=0, so they pass the carry through unchanged and the root carry-out
    // equals the carry out of bit DATA_W-1.
    for (genvar r = 0; r <= LEVELS; r++) begin : g_row
        localparam int unsigned NODES = pow4(LEVELS - r);

        logic [4*NODES-1:0] p_in;
        logic [4*NODES-1:0] g_in;
        logic [4*NODES-1:0] c_lane;  // carry into each child of this row
        logic [NODES-1:0]   p_node;
        logic [NODES-1:0]   g_node;
        logic [NODES-1:0]   c_node;  // carry into each node of this row

        if (r == 0) begin : g_leaf
            always_comb begin
                p_in               = '1;
                g_in               = '0;
                p_in[DATA_W-1:0]   = p_bit;
                g_in[DATA_W-1:0]   = g_bit;
            end
        end else begin : g_inner
            assign p_in = g_row[r-1].p_node;
            assign g_in = g_row[r-1].g_node;
        end

        if (r == LEVELS) begin : g_root
            assign c_node = c0;
        end else begin : g_child
            assign c_node = g_row[r+1].c_lane;
        end

        for (genvar k = 0; k < NODES; k++) begin : g_lcu
            assign c_lane[4*k] = c_node[k];

            cla_lcu4 u_lcu (
                .p     (p_in[4*k +: 4]),
                .g     (g_in[4*k +: 4]),
                .c_in  (c_node[k]),
                .carry (c_lane[4*k+1 +: 3]),
                .g_out (g_node[k]),
                .p_out (p_node[k])
            );
        end
    end

    assign c_bit[DATA_W-1:0] = g_row[0].c_lane[DATA_W-1:0];
    assign c_bit[DATA_W]     = g_row[LEVELS].g_node[0] | (g_row[LEVELS].p_node[0] & c0);

    // ---------------------------------------------------------------- stage 1 regs
    logic              v1_q;
    logic [DATA_W-1:0] p_q;
    logic [DATA_W:0]   c_q;

    // ---------------------------------------------------------------- stage 2 comb
    logic [DATA_W-1:0] sum_d;
    logic              cout_d;
    logic              ovf_d;

    always_comb begin
        sum_d  = p_q ^ c_q[DATA_W-1:0];
        cout_d = c_q[DATA_W];
    end

    if (SIGNED_OVF) begin : g_ovf
        assign ovf_d = c_q[DATA_W] ^ c_q[DATA_W-1];
    end else begin : g_no_ovf
        assign ovf_d = 1'b0;
    end

    // ---------------------------------------------------------------- stage 2 regs
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic              ovf_q;

    // Data registers load only alongside a valid token so X operands on bubbles never
    // reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            p_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            v1_q        <= in_valid;
            out_valid_q <= v1_q;
            if (in_valid) begin
                p_q <= p_bit;
                c_q <= c_bit;
            end
            if (v1_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (DATA_W=64): directed corner cases, latency,
// back-to-back streaming, backpressure, reset flush and randomized traffic against an
// arithmetic reference model and an in-order scoreboard.
module tb_cla_pipe_adder;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .DATA_W     (W),
        .GROUP_W    (4),
        .SIGNED_OVF (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t         exp_q[$];
    res_t         e;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_in     = 0;
    int           n_out    = 0;
    logic         was_stall = 1'b0;
    logic [W-1:0] prev_sum;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Reference: plain integer arithmetic. Overflow means the exact signed result does not
    // fit in W signed bits.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        res_t               r;
        logic [W+1:0]       u;
        logic signed [W+1:0] sx;
        logic signed [W+1:0] sy;
        logic signed [W+1:0] sr;
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        if (s) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sr     = sx - sy;
        end else begin
            u      = {2'b00, x} + {2'b00, y} + {{(W+1){1'b0}}, ci};
            r.sum  = u[W-1:0];
            r.cout = u[W];
            sr     = sx + sy + $signed({{(W+1){1'b0}}, ci});
        end
        r.ovf = (sr[W+1:W-1] != {3{sr[W-1]}});
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: pop/compare on output transfer, push model result on input transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (was_stall) check("hold_sum", sum, prev_sum);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
                    check("ovf", ovf, e.ovf);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                n_in++;
            end
            was_stall = out_valid && !out_ready;
            prev_sum  = sum;
        end else begin
            was_stall = 1'b0;
        end
    end

    // Called just after a posedge with out_ready=1; checks 2-cycle latency and the result.
    task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic s, input logic [W-1:0] w_sum,
                           input logic w_cout, input logic w_ovf);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lat2_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, w_sum);
        check({tag, "_cout"}, cout, w_cout);
        check({tag, "_ovf"}, ovf, w_ovf);
        @(posedge clk); #1;
    endtask

    logic [15:0] hist;
    logic [15:0] hist_exp;
    res_t        exp1;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;

        // Directed corner cases
        run_one("ripple", '1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        run_one("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_cin_ign", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Back-to-back stream of 8: outputs on 8 consecutive cycles starting at cycle 2
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom};
                    cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    @(negedge clk);
                    hist[j] = out_valid;
                end
            end
        join
        for (int j = 0; j < 16; j++) hist_exp[j] = (j >= 2) && (j < 10);
        check("b2b_valid_pattern", hist, hist_exp);
        @(posedge clk); #1;

        // Backpressure with both stages full
        out_ready = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1; sub = 1'b0;
        exp1 = model(a, b, cin, sub);
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b1;
        @(posedge clk); #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_sum", sum, exp1.sum);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 0);

        // Reset while both stages hold valid data
        out_ready = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'b1;
        @(posedge clk); #1;
        a = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_full", out_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        n_in  = n_in - exp_q.size();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_sum", sum, '0);
        check("flush_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("flush_no_leftover", out_valid, 1'b0);
        @(posedge clk); #1;
        run_one("post_reset", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rand_op(); b = rand_op();
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 0);
        check("in_out_count", n_out, n_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
